if_id_hazard: RTL and testbench
===============================

Name: if_id_hazard

Overview:
IF/ID pipeline register combined with load-use hazard detection for the 5-stage MIPS pipeline.
- Captures the fetched instruction and PC+4 each cycle.
- Decodes the Rs/Rt/Rd fields for the register file and the ID/EX register.
- Detects a load-use dependency against the instruction currently in EX. On a hit it freezes PC and IF/ID and injects a bubble into ID/EX.
- Also handles branch flush and instruction-memory wait, and keeps saturating stall/flush counters.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters.
- NOP_WORD, 32'h0000_0000, instruction word loaded on flush or bubble (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PC_Plus4  in  32  PC+4 from the fetch stage.
- Instruction  in  32  word from instruction memory.
- Imem_Ready  in  1  instruction word valid this cycle.
- Branch_Taken  in  1  branch/jump resolved taken; flush the wrong-path instruction.
- Mem_Rd1  in  1  ID/EX-stage instruction is a load.
- Rt1  in  5  ID/EX-stage load destination register.
- Instr_ID  out  32  registered instruction.
- PC_ID  out  32  registered PC+4.
- Valid_ID  out  1  Instr_ID holds a real instruction.
- Rs  out  5  Instr_ID[25:21].
- Rt  out  5  Instr_ID[20:16].
- Rd  out  5  Instr_ID[15:11].
- PC_Write  out  1  PC update enable (0 = hold PC).
- Bubble  out  1  zero all control signals entering ID/EX this cycle.
- Stall_Count  out  CNT_W  cycles stalled by load-use.
- Flush_Count  out  CNT_W  flushes performed.

Behaviour:
- Reset (rst_n=0, asynchronous): Instr_ID=NOP_WORD, PC_ID=0, Valid_ID=0, Stall_Count=0, Flush_Count=0. Rs/Rt/Rd=0 because they derive from Instr_ID. Outputs hold until the first rising edge after release.
- hazard (combinational): Valid_ID & Mem_Rd1 & (Rt1!=0) & ((Rt1==Rs) | (Rt1==Rt)).
- Bubble = hazard & ~Branch_Taken.
- PC_Write = Branch_Taken | (~hazard & Imem_Ready).
- Register update at each posedge, strict priority:
  1. Branch_Taken: Instr_ID<=NOP_WORD, Valid_ID<=0, PC_ID<=PC_Plus4. Flush_Count increments, saturating at all-ones. A flush overrides a hazard and Imem_Ready=0.
  2. hazard: hold Instr_ID, PC_ID and Valid_ID. Stall_Count increments, saturating.
  3. ~Imem_Ready: Instr_ID<=NOP_WORD, Valid_ID<=0, PC_ID holds. Counters unchanged.
  4. Otherwise: Instr_ID<=Instruction, PC_ID<=PC_Plus4, Valid_ID<=1.
- Load-use stall is exactly one cycle per dependency. The bubble clears Mem_Rd1 in ID/EX on the next cycle, so hazard drops without extra state.
- Rt1==0 never stalls, since $zero is never written.
- An invalid Instr_ID never stalls; a NOP cannot create a hazard.
- Counter saturation: at all-ones the value holds, with no wrap.
- Reset asserted mid-stall or mid-flush: immediate return to reset values; no pending state survives.

Decomposition:
- Shared package mips_pkg: NOP_WORD; field bit positions RS_MSB/LSB, RT_MSB/LSB, RD_MSB/LSB; REG_ZERO=5'd0.
- One sub-module, sat_counter (parameter CNT_W; inputs clk, rst_n, inc; output count), instantiated twice for the stall and flush counters.
- Hazard compare stays inline.

Test Plan:
- Reset: hold rst_n=0 and drive Instruction=32'h8C22_0004 → Instr_ID=0, Valid_ID=0, both counters 0. Release with Imem_Ready=1 → next edge Instr_ID=32'h8C22_0004, PC_ID=PC_Plus4, Valid_ID=1.
- Load-use hit: ID holds add $3,$2,$4 (Rs=2), with Mem_Rd1=1, Rt1=2 → Bubble=1, PC_Write=0, IF/ID held one cycle, Stall_Count=1. Then Mem_Rd1=0 → normal advance.
- No-stall cases: Rt1=0 with Mem_Rd1=1, or Mem_Rd1=0 with Rt1=2 → Bubble=0, PC_Write=1, Stall_Count unchanged.
- Flush beats hazard: Branch_Taken=1 while a hazard condition holds → Instr_ID=0, Valid_ID=0, PC_Write=1, Bubble=0, Flush_Count+1, Stall_Count unchanged.
- Imem wait: Imem_Ready=0 for 3 cycles → PC_Write=0, Valid_ID=0, Instr_ID=0, PC_ID held; resumes on Imem_Ready=1.
- Saturation and async reset: with CNT_W=2, cause 5 stalls → Stall_Count=3. Assert rst_n=0 mid-cycle while Bubble=1 → all outputs reset before the next edge.

Source files
------------

// File: rtl/if_id_hazard_pkg.sv
// Shared MIPS pipeline constants for the IF/ID stage.
//   NOP_WORD          : sll $0,$0,0, loaded on flush or bubble
//   RS/RT/RD_MSB/LSB  : register-specifier bit positions in an R/I-type word
//   REG_ZERO          : register $zero, never written, never a hazard source
//   upd_sel_e         : which IF/ID update path wins this cycle
package mips_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;
    localparam int unsigned RD_MSB = 15;
    localparam int unsigned RD_LSB = 11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        UPD_LOAD  = 2'd0,   // normal advance
        UPD_WAIT  = 2'd1,   // instruction memory not ready
        UPD_STALL = 2'd2,   // load-use hold
        UPD_FLUSH = 2'd3    // branch taken, discard wrong path
    } upd_sel_e;

endpackage

// File: rtl/if_id_hazard_if.sv
// IF/ID hazard bus.
//   master : fetch/EX side, drives PC_Plus4, Instruction, Imem_Ready,
//            Branch_Taken, Mem_Rd1, Rt1 and observes the rest
//   slave  : the if_id_hazard block
interface if_id_hazard_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      PC_Plus4;
    logic [31:0]      Instruction;
    logic             Imem_Ready;
    logic             Branch_Taken;
    logic             Mem_Rd1;
    logic [4:0]       Rt1;
    logic [31:0]      Instr_ID;
    logic [31:0]      PC_ID;
    logic             Valid_ID;
    logic [4:0]       Rs;
    logic [4:0]       Rt;
    logic [4:0]       Rd;
    logic             PC_Write;
    logic             Bubble;
    logic [CNT_W-1:0] Stall_Count;
    logic [CNT_W-1:0] Flush_Count;

    modport master (
        output PC_Plus4, Instruction, Imem_Ready, Branch_Taken, Mem_Rd1, Rt1,
        input  Instr_ID, PC_ID, Valid_ID, Rs, Rt, Rd, PC_Write, Bubble,
               Stall_Count, Flush_Count
    );

    modport slave (
        input  PC_Plus4, Instruction, Imem_Ready, Branch_Taken, Mem_Rd1, Rt1,
        output Instr_ID, PC_ID, Valid_ID, Rs, Rt, Rd, PC_Write, Bubble,
               Stall_Count, Flush_Count
    );
endinterface

// File: rtl/if_id_hazard_sat_counter.sv
// Saturating up-counter for pipeline performance statistics.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears count
//   inc   : add one this cycle (ignored once at all-ones)
//   count : current value
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use hazard detection.
//   clk   : pipeline clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of if_id_hazard_if; fetch inputs, EX load info,
//           registered ID instruction/PC, decoded Rs/Rt/Rd, PC_Write,
//           Bubble and saturating stall/flush counters
module if_id_hazard #(
    parameter int unsigned CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic          clk,
    input  logic          rst_n,
    if_id_hazard_if.slave bus
);
    import mips_pkg::*;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q,    pc_d;
    logic        valid_q, valid_d;
    logic        hazard;
    upd_sel_e    upd_sel;

    // Rs/Rt are taken from the registered word, so a NOP (invalid) slot
    // is additionally masked by valid_q.
    assign hazard = valid_q && bus.Mem_Rd1 && (bus.Rt1 != REG_ZERO) &&
                    ((bus.Rt1 == instr_q[RS_MSB:RS_LSB]) ||
                     (bus.Rt1 == instr_q[RT_MSB:RT_LSB]));

    always_comb begin
        upd_sel = UPD_LOAD;
        if (bus.Branch_Taken) begin
            upd_sel = UPD_FLUSH;
        end else if (hazard) begin
            upd_sel = UPD_STALL;
        end else if (!bus.Imem_Ready) begin
            upd_sel = UPD_WAIT;
        end
    end

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        case (upd_sel)
            UPD_FLUSH: begin
                instr_d = NOP_WORD;
                pc_d    = bus.PC_Plus4;
                valid_d = 1'b0;
            end
            UPD_STALL: ;
            UPD_WAIT: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end
            default: begin
                instr_d = bus.Instruction;
                pc_d    = bus.PC_Plus4;
                valid_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_WORD;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (upd_sel == UPD_STALL),
        .count (bus.Stall_Count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (upd_sel == UPD_FLUSH),
        .count (bus.Flush_Count)
    );

    assign bus.Instr_ID = instr_q;
    assign bus.PC_ID    = pc_q;
    assign bus.Valid_ID = valid_q;
    assign bus.Rs       = instr_q[RS_MSB:RS_LSB];
    assign bus.Rt       = instr_q[RT_MSB:RT_LSB];
    assign bus.Rd       = instr_q[RD_MSB:RD_LSB];
    assign bus.Bubble   = hazard && !bus.Branch_Taken;
    assign bus.PC_Write = bus.Branch_Taken || (!hazard && bus.Imem_Ready);

endmodule

// File: tb/tb_if_id_hazard.sv
// Directed bench for if_id_hazard: a CNT_W=16 instance plus a CNT_W=2
// instance sharing the same stimulus for the saturation scenario.
module tb_if_id_hazard;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    localparam logic [31:0] LW_WORD  = 32'h8C22_0004; // lw  $2,4($1)
    localparam logic [31:0] ADD_A    = 32'h0044_1820; // add $3,$2,$4
    localparam logic [31:0] ADD_B    = 32'h00A6_3820; // add $7,$5,$6

    always #5 clk = ~clk;

    if_id_hazard_if #(.CNT_W(16)) bus  ();
    if_id_hazard_if #(.CNT_W(2))  sbus ();

    assign sbus.PC_Plus4     = bus.PC_Plus4;
    assign sbus.Instruction  = bus.Instruction;
    assign sbus.Imem_Ready   = bus.Imem_Ready;
    assign sbus.Branch_Taken = bus.Branch_Taken;
    assign sbus.Mem_Rd1      = bus.Mem_Rd1;
    assign sbus.Rt1          = bus.Rt1;

    if_id_hazard #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    if_id_hazard #(.CNT_W(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.Instruction  = LW_WORD;
        bus.PC_Plus4     = 32'h0000_0104;
        bus.Imem_Ready   = 1'b1;
        bus.Branch_Taken = 1'b0;
        bus.Mem_Rd1      = 1'b0;
        bus.Rt1          = 5'd0;
        #3;
        n_checks++;
        if (bus.Instr_ID !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want %h", bus.Instr_ID, 32'h0); end
        n_checks++;
        if (bus.Valid_ID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.Valid_ID); end
        n_checks++;
        if (bus.PC_ID !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", bus.PC_ID); end
        n_checks++;
        if (bus.Stall_Count !== 16'd0 || bus.Flush_Count !== 16'd0) begin
            n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", bus.Stall_Count, bus.Flush_Count);
        end
        tick();
        tick();
        n_checks++;
        if (bus.Instr_ID !== 32'h0) begin n_fail++; $display("FAIL reset_hold: got %h want 0", bus.Instr_ID); end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.Instr_ID !== LW_WORD) begin n_fail++; $display("FAIL first_instr: got %h want %h", bus.Instr_ID, LW_WORD); end
        n_checks++;
        if (bus.PC_ID !== 32'h0000_0104 || bus.Valid_ID !== 1'b1) begin
            n_fail++; $display("FAIL first_pc_valid: got %h/%b want 00000104/1", bus.PC_ID, bus.Valid_ID);
        end
        n_checks++;
        if (bus.Rs !== 5'd1 || bus.Rt !== 5'd2) begin
            n_fail++; $display("FAIL first_fields: got rs=%0d rt=%0d want 1/2", bus.Rs, bus.Rt);
        end
    endtask

    task automatic test_load_use();
        bus.Instruction = ADD_A;
        bus.PC_Plus4    = 32'h0000_0108;
        tick();
        n_checks++;
        if (bus.Rs !== 5'd2 || bus.Rt !== 5'd4 || bus.Rd !== 5'd3) begin
            n_fail++; $display("FAIL add_fields: got %0d/%0d/%0d want 2/4/3", bus.Rs, bus.Rt, bus.Rd);
        end
        bus.Mem_Rd1     = 1'b1;
        bus.Rt1         = 5'd2;
        bus.Instruction = ADD_B;
        bus.PC_Plus4    = 32'h0000_010C;
        #1;
        n_checks++;
        if (bus.Bubble !== 1'b1 || bus.PC_Write !== 1'b0) begin
            n_fail++; $display("FAIL lu_ctrl: got bubble=%b pcw=%b want 1/0", bus.Bubble, bus.PC_Write);
        end
        tick();
        n_checks++;
        if (bus.Instr_ID !== ADD_A || bus.PC_ID !== 32'h0000_0108) begin
            n_fail++; $display("FAIL lu_hold: got %h/%h want %h/00000108", bus.Instr_ID, bus.PC_ID, ADD_A);
        end
        n_checks++;
        if (bus.Stall_Count !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want 1", bus.Stall_Count); end
        bus.Mem_Rd1 = 1'b0;
        #1;
        n_checks++;
        if (bus.Bubble !== 1'b0 || bus.PC_Write !== 1'b1) begin
            n_fail++; $display("FAIL lu_release: got bubble=%b pcw=%b want 0/1", bus.Bubble, bus.PC_Write);
        end
        tick();
        n_checks++;
        if (bus.Instr_ID !== ADD_B || bus.PC_ID !== 32'h0000_010C) begin
            n_fail++; $display("FAIL lu_advance: got %h/%h want %h/0000010c", bus.Instr_ID, bus.PC_ID, ADD_B);
        end
    endtask

    task automatic test_no_stall();
        bus.Instruction = ADD_A;
        bus.PC_Plus4    = 32'h0000_0110;
        tick();
        bus.Mem_Rd1 = 1'b1;
        bus.Rt1     = 5'd0;
        #1;
        n_checks++;
        if (bus.Bubble !== 1'b0 || bus.PC_Write !== 1'b1) begin
            n_fail++; $display("FAIL ns_rt1_zero: got bubble=%b pcw=%b want 0/1", bus.Bubble, bus.PC_Write);
        end
        bus.Rt1 = 5'd4;
        #1;
        n_checks++;
        if (bus.Bubble !== 1'b1) begin n_fail++; $display("FAIL rt_match: got bubble=%b want 1", bus.Bubble); end
        bus.Mem_Rd1 = 1'b0;
        bus.Rt1     = 5'd2;
        #1;
        n_checks++;
        if (bus.Bubble !== 1'b0 || bus.PC_Write !== 1'b1) begin
            n_fail++; $display("FAIL ns_no_load: got bubble=%b pcw=%b want 0/1", bus.Bubble, bus.PC_Write);
        end
        bus.PC_Plus4 = 32'h0000_0114;
        tick();
        n_checks++;
        if (bus.Stall_Count !== 16'd1 || bus.PC_ID !== 32'h0000_0114) begin
            n_fail++; $display("FAIL ns_advance: got cnt=%0d pc=%h want 1/00000114", bus.Stall_Count, bus.PC_ID);
        end
    endtask

    task automatic test_flush();
        bus.Mem_Rd1      = 1'b1;
        bus.Rt1          = 5'd2;
        bus.Branch_Taken = 1'b1;
        bus.Imem_Ready   = 1'b0;
        bus.PC_Plus4     = 32'h0000_0200;
        #1;
        n_checks++;
        if (bus.Bubble !== 1'b0 || bus.PC_Write !== 1'b1) begin
            n_fail++; $display("FAIL fl_ctrl: got bubble=%b pcw=%b want 0/1", bus.Bubble, bus.PC_Write);
        end
        tick();
        n_checks++;
        if (bus.Instr_ID !== 32'h0 || bus.Valid_ID !== 1'b0 || bus.PC_ID !== 32'h0000_0200) begin
            n_fail++; $display("FAIL fl_regs: got %h/%b/%h want 0/0/00000200", bus.Instr_ID, bus.Valid_ID, bus.PC_ID);
        end
        n_checks++;
        if (bus.Flush_Count !== 16'd1 || bus.Stall_Count !== 16'd1) begin
            n_fail++; $display("FAIL fl_counts: got flush=%0d stall=%0d want 1/1", bus.Flush_Count, bus.Stall_Count);
        end
        bus.Branch_Taken = 1'b0;
        bus.Imem_Ready   = 1'b1;
        #1;
        n_checks++;
        if (bus.Bubble !== 1'b0) begin n_fail++; $display("FAIL nop_no_hazard: got bubble=%b want 0", bus.Bubble); end
        bus.Mem_Rd1 = 1'b0;
    endtask

    task automatic test_imem_wait();
        bus.Instruction = ADD_A;
        bus.PC_Plus4    = 32'h0000_0204;
        tick();
        bus.Imem_Ready  = 1'b0;
        bus.Instruction = LW_WORD;
        bus.PC_Plus4    = 32'h0000_0208;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.Instr_ID !== 32'h0 || bus.Valid_ID !== 1'b0 || bus.PC_ID !== 32'h0000_0204 || bus.PC_Write !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_%0d: got %h/%b/%h pcw=%b want 0/0/00000204/0", i, bus.Instr_ID, bus.Valid_ID, bus.PC_ID, bus.PC_Write);
            end
        end
        bus.Imem_Ready = 1'b1;
        tick();
        n_checks++;
        if (bus.Instr_ID !== LW_WORD || bus.PC_ID !== 32'h0000_0208 || bus.Valid_ID !== 1'b1) begin
            n_fail++; $display("FAIL wait_resume: got %h/%h/%b want %h/00000208/1", bus.Instr_ID, bus.PC_ID, bus.Valid_ID, LW_WORD);
        end
        n_checks++;
        if (bus.Stall_Count !== 16'd1 || bus.Flush_Count !== 16'd1) begin
            n_fail++; $display("FAIL wait_counts: got %0d/%0d want 1/1", bus.Stall_Count, bus.Flush_Count);
        end
    endtask

    task automatic test_saturation_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        bus.Instruction = ADD_A;
        bus.PC_Plus4    = 32'h0000_0300;
        bus.Mem_Rd1     = 1'b0;
        tick();
        bus.Mem_Rd1 = 1'b1;
        bus.Rt1     = 5'd2;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (sbus.Stall_Count !== 2'd3) begin n_fail++; $display("FAIL sat_stall: got %0d want 3", sbus.Stall_Count); end
        n_checks++;
        if (bus.Stall_Count !== 16'd5) begin n_fail++; $display("FAIL wide_stall: got %0d want 5", bus.Stall_Count); end
        n_checks++;
        if (bus.Instr_ID !== ADD_A || bus.PC_ID !== 32'h0000_0300 || bus.Bubble !== 1'b1) begin
            n_fail++; $display("FAIL sat_hold: got %h/%h bubble=%b want %h/00000300/1", bus.Instr_ID, bus.PC_ID, bus.Bubble, ADD_A);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.Instr_ID !== 32'h0 || bus.Valid_ID !== 1'b0 || bus.PC_ID !== 32'h0) begin
            n_fail++; $display("FAIL async_regs: got %h/%b/%h want 0/0/0", bus.Instr_ID, bus.Valid_ID, bus.PC_ID);
        end
        n_checks++;
        if (bus.Stall_Count !== 16'd0 || sbus.Stall_Count !== 2'd0 || bus.Bubble !== 1'b0 || bus.PC_Write !== 1'b1) begin
            n_fail++;
            $display("FAIL async_ctrl: got stall=%0d sstall=%0d bubble=%b pcw=%b want 0/0/0/1", bus.Stall_Count, sbus.Stall_Count, bus.Bubble, bus.PC_Write);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_flush();
        test_imem_wait();
        test_saturation_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
